// File: rtl/seq_11011_pkg.sv
// Shared definitions for the 11011 serial link (transmitter and detector).
package seq_11011_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    // Sync pattern that opens every frame, sent MSB first
    localparam int unsigned              SYNC_W     = 5;
    localparam logic [SYNC_W-1:0]        SYNC_11011 = 5'b11011;

endpackage

// File: rtl/seq_11011_tx_piso_shift.sv
// Parallel-load, MSB-first shift register used for the sync and payload fields.
module piso_shift #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] d,
    output logic         q_msb
);

    logic [W-1:0] q;

    // Load has priority over shift; zeros fill in from the LSB side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= q << 1;
        end
    end

    assign q_msb = q[W-1];

endmodule

// File: rtl/seq_11011_tx.sv
// Serial frame transmitter: sync 11011, payload MSB first, even parity, idle gap.
module seq_11011_tx
    import seq_11011_pkg::*;
#(
    parameter int unsigned          DATA_W  = 8,
    parameter int unsigned          SYNC_W  = seq_11011_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0]    SYNC    = SYNC_11011,
    parameter int unsigned          GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int unsigned MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAX_C  = (MAX_SD > GAP_CYC) ? MAX_SD : GAP_CYC;
    localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             parity;
    logic             accept;
    logic             sync_bit, data_bit;
    logic             bit_nxt, vld_nxt, done_nxt;

    assign accept = tx_valid & tx_ready;

    piso_shift #(.W(SYNC_W)) u_sync_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift_en (state == seq_11011_pkg::SYNC),
        .d        (SYNC),
        .q_msb    (sync_bit)
    );

    piso_shift #(.W(DATA_W)) u_data_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift_en (state == seq_11011_pkg::DATA),
        .d        (tx_data),
        .q_msb    (data_bit)
    );

    // Next state, per-state counter reload, and the bit to register onto the line.
    // Outputs lag the state by one edge, so the first sync bit appears the edge after accept.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            seq_11011_pkg::IDLE: begin
                if (accept) begin
                    state_nxt = seq_11011_pkg::SYNC;
                    cnt_nxt   = CNT_W'(SYNC_W - 1);
                end
            end
            seq_11011_pkg::SYNC: begin
                bit_nxt = sync_bit;
                vld_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = seq_11011_pkg::DATA;
                    cnt_nxt   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            seq_11011_pkg::DATA: begin
                bit_nxt = data_bit;
                vld_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = seq_11011_pkg::PAR;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            seq_11011_pkg::PAR: begin
                bit_nxt   = parity;
                vld_nxt   = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = seq_11011_pkg::GAP;
                cnt_nxt   = CNT_W'(GAP_CYC - 1);
            end
            seq_11011_pkg::GAP: begin
                if (cnt == '0) begin
                    state_nxt = seq_11011_pkg::IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = seq_11011_pkg::IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, parity capture and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= seq_11011_pkg::IDLE;
            cnt      <= '0;
            parity   <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tx_ready <= (state_nxt == seq_11011_pkg::IDLE);
            if (accept) begin
                parity <= ^tx_data;
            end
        end
    end

    // Registered line outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            data_out   <= bit_nxt;
            out_valid  <= vld_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_11011_tx.sv
// Self-checking bench for seq_11011_tx with a frame-level reference model.
module tb_seq_11011_tx;

    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int FL  = 5 + DW + 1;
    localparam int LEN = 4 + FL + GAP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, data_out, out_valid, frame_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    int a1 = 0;
    logic obs_bits [FL+GAP];
    logic s_exp [LEN];
    logic s_obs [LEN];
    logic [31:0] m_exp, m_obs;
    logic [FL-1:0] fr;

    always #5 clk = ~clk;

    seq_11011_tx #(.DATA_W(DW), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done === 1'b1) done_cnt++;
    endtask

    // Expected frame as a bit vector: sync, payload, even parity
    function automatic logic [FL-1:0] frame_of(input logic [DW-1:0] w);
        return {5'b11011, w, ^w};
    endfunction

    task automatic run_frame(input logic [DW-1:0] w, input bit hold, input bit noise);
        int guard = 0;
        logic [FL-1:0] f;
        f = frame_of(w);
        while (tx_ready !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        chk("ready_before_accept", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        acc_cyc = cyc;
        chk("ready_drop", tx_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        if (!hold) tx_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (noise) begin
                tx_data = DW'($urandom);
                if (!hold) tx_valid = 1'($urandom);
            end
            step();
            obs_bits[i] = data_out;
            chk("frame_bit", data_out, f[FL-1-i]);
            chk("frame_valid", out_valid, 1);
            chk("frame_done", frame_done, (i == FL-1) ? 1 : 0);
            chk("ready_busy", tx_ready, 0);
        end
        for (int g = 0; g < GAP; g++) begin
            tx_valid = hold;
            step();
            obs_bits[FL+g] = data_out;
            chk("gap_valid", out_valid, 0);
            chk("gap_data", data_out, 0);
            chk("gap_done", frame_done, 0);
            chk("gap_ready", tx_ready, (g == GAP-1) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset held with tx_valid high
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", tx_ready, 0);
            chk("rst_data", data_out, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_done", frame_done, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("ready_at_release", tx_ready, 0);
        tx_valid = 1'b0;
        step();
        chk("ready_after_release", tx_ready, 1);

        // Directed frames
        run_frame(8'hA5, 1'b0, 1'b0);
        run_frame(8'h07, 1'b0, 1'b1);

        // Back-to-back with tx_valid held high
        done_cnt = 0;
        run_frame(8'hFF, 1'b1, 1'b1);
        a1 = acc_cyc;
        run_frame(8'h00, 1'b1, 1'b1);
        tx_valid = 1'b0;
        chk("b2b_spacing", 32'(acc_cyc - a1), 17);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_no_extra_frame", out_valid, 0);
            chk("b2b_ready_held", tx_ready, 1);
        end
        chk("b2b_done_pulses", 32'(done_cnt), 2);

        // Reset during third payload bit of 8'h3C
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mid_bit3", data_out, 1);
        chk("mid_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_ready", tx_ready, 0);
        chk("async_data", data_out, 0);
        chk("async_valid", out_valid, 0);
        chk("async_done", frame_done, 0);
        step();
        step();
        chk("abort_valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_low", tx_ready, 0);
        step();
        chk("abort_ready_high", tx_ready, 1);
        chk("abort_no_resume", out_valid, 0);
        run_frame(8'h81, 1'b0, 1'b0);

        // Random payloads with input noise mid-frame
        for (int n = 0; n < 6; n++) run_frame(DW'($urandom), 1'b0, 1'b1);

        // Loopback: 11011 occurrences in observed line vs expected frame
        run_frame(8'hDB, 1'b0, 1'b0);
        fr = frame_of(8'hDB);
        for (int k = 0; k < LEN; k++) begin
            s_exp[k] = 1'b0;
            s_obs[k] = 1'b0;
        end
        for (int i = 0; i < FL; i++) s_exp[4+i] = fr[FL-1-i];
        for (int i = 0; i < FL + GAP; i++) s_obs[4+i] = obs_bits[i];
        m_exp = '0;
        m_obs = '0;
        for (int k = 4; k < LEN; k++) begin
            if ({s_exp[k-4], s_exp[k-3], s_exp[k-2], s_exp[k-1], s_exp[k]} == 5'b11011) m_exp[k] = 1'b1;
            if ({s_obs[k-4], s_obs[k-3], s_obs[k-2], s_obs[k-1], s_obs[k]} == 5'b11011) m_obs[k] = 1'b1;
        end
        chk("loopback_hits", m_obs, m_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
